// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: program-image memory with a sequential fetch engine and a one-entry output buffer.
// Define IFM_WRITE_PORT_EN to add the wr_en/wr_addr/wr_data program load port.
module instr_fetch_mem #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned WRAP      = 1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              end_of_prog
`ifdef IFM_WRITE_PORT_EN
    ,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
`endif
);

    typedef enum logic {
        StRun,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] NopWord  = DATA_W'(NOP_INSTR);

    function automatic logic [DATA_W-1:0] image_word(input int unsigned idx);
        logic [31:0] w;
        case (idx % 3)
            0:       w = 32'h00A0_0093;
            1:       w = 32'h0010_8133;
            default: w = 32'h0020_8203;
        endcase
        return DATA_W'(w);
    endfunction

    // ------------------------------------------------------------------
    // Program storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_rd [DEPTH];

`ifdef IFM_WRITE_PORT_EN
    // Each word is held as a delta against the built-in image, so storage that powers up
    // at zero presents the original program without any load sequence.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_W-1:0] delta_q;

        always_ff @(posedge clock) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                delta_q <= wr_data ^ image_word(i);
            end
        end

        assign mem_rd[i] = image_word(i) ^ delta_q;
    end
`else
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign mem_rd[i] = image_word(i);
    end
`endif

    // ------------------------------------------------------------------
    // Fetch engine
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              eop_q, eop_d;

    logic              load_ok;
    logic              pc_in_range;
    logic              pc_is_last;
    logic [DATA_W-1:0] rd_data;

    assign load_ok     = !valid_q || instr_ready;
    assign pc_in_range = {1'b0, pc_q} < DepthW;
    // Addresses past the image (reachable only by redirect) count as the last word.
    assign pc_is_last  = pc_q >= LastAddr;
    assign rd_data     = pc_in_range ? mem_rd[pc_q] : NopWord;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        eop_d   = eop_q;

        if (redirect_valid) begin
            pc_d    = redirect_addr;
            valid_d = 1'b0;
            eop_d   = 1'b0;
            state_d = StRun;
        end else if ((state_q == StRun) && fetch_en && load_ok) begin
            instr_d = rd_data;
            addr_d  = pc_q;
            valid_d = 1'b1;
            if (!pc_is_last) begin
                pc_d = pc_q + ADDR_W'(1);
            end else if (WRAP != 0) begin
                pc_d = '0;
            end else begin
                state_d = StDone;
                eop_d   = 1'b1;
            end
        end else if (load_ok) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            addr_q  <= '0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            eop_q   <= eop_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_addr  = addr_q;
    assign end_of_prog = eop_q;

    // A stalled word must not change until it is taken or flushed.
    assert property (@(posedge clock)
        (!reset && valid_q && !instr_ready && !redirect_valid) |=>
            (reset || ($stable(instr_q) && $stable(addr_q) && valid_q)));

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised instruction memory with a sequential fetch engine. It holds the program image and owns the program counter. It delivers one instruction per cycle over a valid/ready handshake, supports a redirect (jump) that flushes the in-flight word, and can either wrap or halt at the end of the image. It sits between the program image and the decode stage of the core.

## Interface
- DATA_W, 32: instruction width in bits
- DEPTH, 64: number of instruction words
- ADDR_W, $clog2(DEPTH): PC width
- WRAP, 1: 1 = PC wraps DEPTH-1 -> 0; 0 = halt after DEPTH-1
- NOP_INSTR, 32'h0000_0013: word returned for out-of-range addresses (truncated/zero-extended to DATA_W)
- Reset is synchronous and active-high.
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- fetch_en  input  1  permission to fetch the next word
- redirect_valid  input  1  load PC with redirect_addr; flush output
- redirect_addr  input  ADDR_W  new PC
- instr_valid  output  1  instr/instr_addr hold a valid word
- instr_ready  input  1  downstream accepts the word
- instr  output  DATA_W  fetched instruction
- instr_addr  output  ADDR_W  address instr was fetched from
- end_of_prog  output  1  WRAP=0 only: last word fetched, engine halted
- wr_en / wr_addr / wr_data  input  1 / ADDR_W / DATA_W  program load port (only with IFM_WRITE_PORT_EN)

## Operation
- Memory image at time zero, word i, selected by i mod 3:
  - 0: 32'h00A0_0093
  - 1: 32'h0010_8133
  - 2: 32'h0020_8203
  - Values are truncated or zero-extended to DATA_W. Memory is not cleared by reset.
- FSM states RUN and DONE. Reset enters RUN.
- load_ok = !instr_valid || instr_ready. The output register is a one-entry buffer.
- Transitions evaluated each cycle, in priority order:
  - redirect_valid: pc <= redirect_addr; instr_valid <= 0; end_of_prog <= 0; state <= RUN. No fetch this cycle. Any unaccepted word is dropped.
  - RUN && fetch_en && load_ok: instr <= mem[pc]; instr_addr <= pc; instr_valid <= 1. Then:
    - pc != DEPTH-1: pc <= pc+1.
    - pc == DEPTH-1 and WRAP=1: pc <= 0.
    - pc == DEPTH-1 and WRAP=0: state <= DONE; end_of_prog <= 1; pc unchanged.
  - load_ok and no fetch: instr_valid <= 0 (instr/instr_addr keep their last value).
  - otherwise: hold all outputs. This is backpressure; instr must stay stable while instr_valid && !instr_ready.
- In DONE, fetch_en is ignored. Only redirect or reset leaves DONE.
- Reads at pc >= DEPTH (non-power-of-2 DEPTH via redirect) return NOP_INSTR. pc still advances and wraps as above, treating >= DEPTH-1 as the last word.

## Timing
- Reset values:
  - instr = 0, instr_addr = 0, instr_valid = 0, end_of_prog = 0
  - pc = 0, state = RUN
- Fetch latency: fetch_en high with load_ok at edge N gives instr_valid/instr at edge N+1.
- Throughput: 1 word/cycle when instr_ready stays high.
- Redirect: instr_valid is low the cycle after redirect_valid. The first word from redirect_addr appears 2 edges after the redirect edge, if fetch_en is held.
- Redirect and accept in the same cycle: the accept completes and the redirect takes effect; no fetch.
- Reset mid-operation: all registers return to reset values on that edge; an in-flight word is lost.
- Write port: takes effect at the edge. A same-cycle read of the same address returns the old data (read-before-write).

## Configuration
- IFM_WRITE_PORT_EN:
  - Defined: wr_en/wr_addr/wr_data ports exist. wr_en=1 writes wr_data to mem[wr_addr] every edge, independent of FSM state and reset. Writes with wr_addr >= DEPTH are ignored.
  - Undefined: the ports are absent and memory is read-only with the time-zero image.

## Test plan
- Reset, then fetch_en=1, instr_ready=1 for 4 cycles -> instr = 00A00093, 00108133, 00208203, 00A00093; instr_addr = 0, 1, 2, 3; instr_valid high from cycle 1.
- Backpressure: hold instr_ready=0 for 3 cycles while word @addr 1 is valid -> instr = 00108133 stable, pc stays 2. Release -> addr 2 arrives on the next edge with no gap or duplicate.
- Redirect to 10 while word @addr 5 is valid and unaccepted -> word 5 dropped, instr_valid low 1 cycle, next word instr_addr = 10, instr = 00108133 (10 mod 3 = 1).
- WRAP=0, DEPTH=8, continuous fetch -> after addr 7, end_of_prog=1 and no further valid words. Redirect to 0 -> end_of_prog=0 and fetch resumes from addr 0. With WRAP=1, addr 7 is followed by addr 0.
- IFM_WRITE_PORT_EN: write 32'hDEAD_BEEF to addr 3 in the same cycle addr 3 is fetched -> that word returns 00A00093. Redirect to 3 -> returns DEADBEEF.
- Assert reset while instr_valid=1 -> next cycle all outputs 0 and the following fetch returns addr 0.
